// File: rtl/tick_pkg.sv
// rtl/tick_pkg.sv - shared BCD constants and helpers for the tick counter
package tick_pkg;

    localparam int BCD_WIDTH = 4;
    localparam logic [BCD_WIDTH-1:0] BCD_MAX = 4'd9;
    localparam logic [BCD_WIDTH-1:0] BCD_MIN = 4'd0;

    // Non-decimal nibbles collapse to zero so the count never leaves BCD space.
    function automatic logic [BCD_WIDTH-1:0] bcd_clamp(input logic [BCD_WIDTH-1:0] value);
        return (value > BCD_MAX) ? BCD_MIN : value;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// rtl/bcd_digit.sv - one registered BCD digit with carry/borrow out
module bcd_digit
    import tick_pkg::*;
(
    input  logic                 clock_in,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 dec,
    input  logic                 load,
    input  logic [BCD_WIDTH-1:0] load_digit,
    output logic [BCD_WIDTH-1:0] digit,
    output logic                 carry,
    output logic                 borrow
);

    // Carry/borrow are combinational so a whole 9..9 or 0..0 run ripples in one cycle.
    assign carry  = inc && (digit == BCD_MAX);
    assign borrow = dec && (digit == BCD_MIN);

    always_ff @(posedge clock_in) begin
        if (reset) begin
            digit <= BCD_MIN;
        end else if (load) begin
            digit <= bcd_clamp(load_digit);
        end else if (inc) begin
            digit <= carry ? BCD_MIN : digit + 4'd1;
        end else if (dec) begin
            digit <= borrow ? BCD_MAX : digit - 4'd1;
        end
    end

endmodule

// File: rtl/tick_bcd_counter.sv
// rtl/tick_bcd_counter.sv - BCD up/down counter advanced by edges of a divided tick
module tick_bcd_counter
    import tick_pkg::*;
#(
    parameter int DIGITS     = 4,
    parameter bit BOTH_EDGES = 1'b0
) (
    input  logic                          clock_in,
    input  logic                          reset,
    input  logic                          tick_in,
    input  logic                          enable,
    input  logic                          up_down,
    input  logic                          load,
    input  logic [BCD_WIDTH*DIGITS-1:0]   load_value,
    output logic [BCD_WIDTH*DIGITS-1:0]   count_bcd,
    output logic                          rollover,
    output logic                          tick_seen
);

    logic              tick_prev;
    logic              rising;
    logic              falling;
    logic              qual_edge;
    logic              count_edge;
    logic [DIGITS:0]   inc_chain;
    logic [DIGITS:0]   dec_chain;

    // tick_prev follows tick_in even during reset, so a high tick at release is not an edge.
    always_ff @(posedge clock_in) begin
        tick_prev <= tick_in;
    end

    assign rising     = tick_in & ~tick_prev;
    assign falling    = ~tick_in & tick_prev;
    assign qual_edge  = BOTH_EDGES ? (rising | falling) : rising;

    // Load wins over a coincident edge, so the edge never reaches the digit chain.
    assign count_edge   = qual_edge & enable & ~load;
    assign inc_chain[0] = count_edge & up_down;
    assign dec_chain[0] = count_edge & ~up_down;

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit u_digit (
            .clock_in   (clock_in),
            .reset      (reset),
            .inc        (inc_chain[g]),
            .dec        (dec_chain[g]),
            .load       (load),
            .load_digit (load_value[g*BCD_WIDTH +: BCD_WIDTH]),
            .digit      (count_bcd[g*BCD_WIDTH +: BCD_WIDTH]),
            .carry      (inc_chain[g+1]),
            .borrow     (dec_chain[g+1])
        );
    end

    // A carry or borrow out of the top digit is exactly the wrap condition.
    always_ff @(posedge clock_in) begin
        if (reset) begin
            rollover  <= 1'b0;
            tick_seen <= 1'b0;
        end else begin
            rollover  <= inc_chain[DIGITS] | dec_chain[DIGITS];
            tick_seen <= qual_edge;
        end
    end

endmodule

// File: tb/tb_tick_bcd_counter.sv
// tb/tb_tick_bcd_counter.sv - directed scoreboard bench for tick_bcd_counter
module tb_tick_bcd_counter;

    logic        clock_in = 1'b0;
    logic        reset;
    logic        tick_in;
    logic        enable;
    logic        up_down;
    logic        load;
    logic [15:0] load_value;
    logic [15:0] count_a, count_b;
    logic        roll_a, roll_b;
    logic        seen_a, seen_b;

    typedef struct {
        string       tag;
        logic [15:0] cnt;
        logic        roll;
        logic        seen;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clock_in = ~clock_in;

    tick_bcd_counter #(.DIGITS(4), .BOTH_EDGES(1'b0)) dut_a (
        .clock_in(clock_in), .reset(reset), .tick_in(tick_in), .enable(enable),
        .up_down(up_down), .load(load), .load_value(load_value),
        .count_bcd(count_a), .rollover(roll_a), .tick_seen(seen_a)
    );

    tick_bcd_counter #(.DIGITS(4), .BOTH_EDGES(1'b1)) dut_b (
        .clock_in(clock_in), .reset(reset), .tick_in(tick_in), .enable(enable),
        .up_down(up_down), .load(load), .load_value(load_value),
        .count_bcd(count_b), .rollover(roll_b), .tick_seen(seen_b)
    );

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          t;
        t = v;
        for (int d = 0; d < 4; d++) begin
            r[d*4 +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    task automatic expect_a(input string tag, input int val, input logic roll, input logic seen);
        exp_t e;
        e.tag  = tag;
        e.cnt  = to_bcd(val);
        e.roll = roll;
        e.seen = seen;
        sb.push_back(e);
    endtask

    task automatic cycle_and_check();
        exp_t e;
        @(posedge clock_in);
        #1;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            assert (count_a === e.cnt) else begin
                errors++;
                $error("FAIL %s count observed=%h expected=%h", e.tag, count_a, e.cnt);
            end
            checks++;
            assert (roll_a === e.roll) else begin
                errors++;
                $error("FAIL %s rollover observed=%b expected=%b", e.tag, roll_a, e.roll);
            end
            checks++;
            assert (seen_a === e.seen) else begin
                errors++;
                $error("FAIL %s tick_seen observed=%b expected=%b", e.tag, seen_a, e.seen);
            end
        end
    endtask

    task automatic check_b(input string tag, input int val, input logic seen);
        logic [15:0] want;
        want = to_bcd(val);
        checks++;
        assert (count_b === want) else begin
            errors++;
            $error("FAIL %s count observed=%h expected=%h", tag, count_b, want);
        end
        checks++;
        assert (seen_b === seen) else begin
            errors++;
            $error("FAIL %s tick_seen observed=%b expected=%b", tag, seen_b, seen);
        end
    endtask

    initial begin
        int cnt;
        reset      = 1'b1;
        tick_in    = 1'b1;
        enable     = 1'b1;
        up_down    = 1'b1;
        load       = 1'b0;
        load_value = 16'h0000;

        // Reset with tick_in held high; release must not look like an edge.
        @(posedge clock_in);
        expect_a("reset_hold", 0, 1'b0, 1'b0);
        cycle_and_check();
        reset = 1'b0;
        expect_a("reset_release", 0, 1'b0, 1'b0);
        cycle_and_check();
        check_b("reset_release_b", 0, 1'b0);
        expect_a("reset_settle", 0, 1'b0, 1'b0);
        cycle_and_check();

        // 12 full tick periods counting up.
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick_in = 1'b0;
            expect_a("count_low", cnt, 1'b0, 1'b0);
            cycle_and_check();
            tick_in = 1'b1;
            cnt++;
            expect_a("count_rise", cnt, 1'b0, 1'b1);
            cycle_and_check();
        end
        check_b("count_both_edges", 24, 1'b1);

        // Wrap up from 9999, then back down.
        load = 1'b1; load_value = 16'h9999;
        expect_a("wrap_load", 9999, 1'b0, 1'b0);
        cycle_and_check();
        load = 1'b0; tick_in = 1'b0;
        expect_a("wrap_low", 9999, 1'b0, 1'b0);
        cycle_and_check();
        tick_in = 1'b1; up_down = 1'b1;
        expect_a("wrap_up", 0, 1'b1, 1'b1);
        cycle_and_check();
        expect_a("wrap_up_pulse_end", 0, 1'b0, 1'b0);
        cycle_and_check();
        tick_in = 1'b0; up_down = 1'b0;
        expect_a("wrap_low2", 0, 1'b0, 1'b0);
        cycle_and_check();
        tick_in = 1'b1;
        expect_a("wrap_down", 9999, 1'b1, 1'b1);
        cycle_and_check();
        expect_a("wrap_down_pulse_end", 9999, 1'b0, 1'b0);
        cycle_and_check();

        // Carry and borrow across three digits.
        load = 1'b1; load_value = 16'h0999;
        expect_a("carry_load", 999, 1'b0, 1'b0);
        cycle_and_check();
        load = 1'b0; tick_in = 1'b0;
        expect_a("carry_low", 999, 1'b0, 1'b0);
        cycle_and_check();
        tick_in = 1'b1; up_down = 1'b1;
        expect_a("carry_up", 1000, 1'b0, 1'b1);
        cycle_and_check();
        load = 1'b1; load_value = 16'h1000;
        expect_a("borrow_load", 1000, 1'b0, 1'b0);
        cycle_and_check();
        load = 1'b0; tick_in = 1'b0;
        expect_a("borrow_low", 1000, 1'b0, 1'b0);
        cycle_and_check();
        tick_in = 1'b1; up_down = 1'b0;
        expect_a("borrow_down", 999, 1'b0, 1'b1);
        cycle_and_check();

        // Load coincident with an edge; invalid nibble clamps to zero.
        tick_in = 1'b0;
        expect_a("prio_low", 999, 1'b0, 1'b0);
        cycle_and_check();
        load = 1'b1; load_value = 16'h00A5; tick_in = 1'b1; up_down = 1'b1;
        expect_a("prio_load_edge", 5, 1'b0, 1'b1);
        cycle_and_check();
        load = 1'b0;

        // Disabled: edges still seen, count frozen.
        enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick_in = 1'b0;
            expect_a("disabled_low", 5, 1'b0, 1'b0);
            cycle_and_check();
            tick_in = 1'b1;
            expect_a("disabled_rise", 5, 1'b0, 1'b1);
            cycle_and_check();
        end
        enable = 1'b1;
        expect_a("reenable_high", 5, 1'b0, 1'b0);
        cycle_and_check();
        expect_a("reenable_settle", 5, 1'b0, 1'b0);
        cycle_and_check();

        // Reset overrides a coincident load and edge mid-count.
        tick_in = 1'b0;
        expect_a("midreset_low", 5, 1'b0, 1'b0);
        cycle_and_check();
        reset = 1'b1; load = 1'b1; load_value = 16'h1234; tick_in = 1'b1;
        expect_a("midreset", 0, 1'b0, 1'b0);
        cycle_and_check();
        check_b("midreset_b", 0, 1'b0);
        reset = 1'b0; load = 1'b0;
        expect_a("midreset_release", 0, 1'b0, 1'b0);
        cycle_and_check();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
